// File: rtl/paper_systolic_drain.sv
// -----------------------------------------------------------------------------
// paper_systolic_drain
//
// Sequencer and output stage behind a ROWS x COLS integer systolic PE array.
// A tile first runs the multiply phase, holding enableMul high long enough for
// the skewed operands to flush through the whole array. It then shifts the
// accumulators out of the column tails, one row per beat. Each ACC-bit tail
// value is narrowed to OUT_W bits. The narrowed row is presented on a
// valid/ready stream.
//
// Build option:
//   PAPER_DRAIN_SATURATE_EN  defined   -> narrowing saturates to the signed
//                                         OUT_W range
//                            undefined -> narrowing keeps the low OUT_W bits
//                                         (wrap)
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high; aborts any tile in flight
//   start           in   begin one tile (sampled only while idle)
//   kLen            in   [KW]        reduction length, latched with start
//   enableMul       out  all PEs multiply-accumulate this cycle
//   enableShiftOut  out  all PEs shift cOut <= cIn this cycle
//   colIn           in   [COLS*ACC]  tail cOut of every column, col c at c*ACC
//   outValid        out  outData holds a beat
//   outReady        in   consumer takes the beat when outValid & outReady
//   outData         out  [COLS*OUT_W] narrowed row, col c at c*OUT_W
//   outLast         out  marks the final (ROWS-th) beat of the tile
//   busy            out  a tile is in progress
//   done            out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module paper_systolic_drain #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC   = 32,
  parameter int OUT_W = 16,
  parameter int KW    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [KW-1:0]           kLen,
  output logic                    enableMul,
  output logic                    enableShiftOut,
  input  logic [COLS*ACC-1:0]     colIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [COLS*OUT_W-1:0]   outData,
  output logic                    outLast,
  output logic                    busy,
  output logic                    done
);

  // One extra bit on the multiply counter: kLen + skew must not overflow.
  localparam int CW = KW + 1;
  localparam int BW = $clog2(ROWS + 1);

  // Cycles needed for the operand wavefront to cross the skewed array.
  localparam logic [CW-1:0] SKEW      = CW'(ROWS + COLS - 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BEATS_ALL = BW'(ROWS);
  localparam logic [BW-1:0] BEAT_LAST = BW'(ROWS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

`ifdef PAPER_DRAIN_SATURATE_EN
  // Limits of the signed OUT_W range, held one bit wider than the
  // accumulator so the comparisons stay exact even when OUT_W == ACC.
  localparam logic signed [ACC:0] SAT_ONE = (ACC+1)'(1);
  localparam logic signed [ACC:0] SAT_MAX = (SAT_ONE <<< (OUT_W - 1)) - SAT_ONE;
  localparam logic signed [ACC:0] SAT_MIN = -(SAT_ONE <<< (OUT_W - 1));
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           mulCnt_q, mulCnt_d;
  logic [BW-1:0]           beats_q, beats_d;
  logic                    outValid_q, outValid_d;
  logic                    outLast_q, outLast_d;
  logic [COLS*OUT_W-1:0]   outData_q, outData_d;
  logic                    done_q, done_d;
  logic [COLS*OUT_W-1:0]   narrowed;
  logic                    fire;
  logic                    accept;

  // ---------------------------------------------------------------------------
  // Narrow one ACC-bit two's-complement accumulator to OUT_W bits.
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC-1:0] v);
`ifdef PAPER_DRAIN_SATURATE_EN
    logic signed [ACC:0] w;
    w = {v[ACC-1], v};
    if (w > SAT_MAX) begin
      return OUT_W'(SAT_MAX);
    end else if (w < SAT_MIN) begin
      return OUT_W'(SAT_MIN);
    end else begin
      return OUT_W'(v);
    end
`else
    return OUT_W'(v);
`endif
  endfunction

  always_comb begin
    narrowed = '0;
    for (int c = 0; c < COLS; c++) begin
      narrowed[c*OUT_W +: OUT_W] = narrow(colIn[c*ACC +: ACC]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    mulCnt_d       = mulCnt_q;
    beats_d        = beats_q;
    outValid_d     = outValid_q;
    outLast_d      = outLast_q;
    outData_d      = outData_q;
    done_d         = 1'b0;
    enableMul      = 1'b0;
    enableShiftOut = 1'b0;
    fire           = 1'b0;
    accept         = outValid_q & outReady;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mulCnt_d = {1'b0, kLen} + SKEW;
          beats_d  = '0;
          // A zero-length reduction skips straight to draining.
          state_d  = (kLen != '0) ? S_MUL : S_SHIFT;
        end
      end

      S_MUL: begin
        enableMul = 1'b1;
        mulCnt_d  = mulCnt_q - CNT_ONE;
        if (mulCnt_q <= CNT_ONE) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A new beat may be issued when the output register is empty or is
        // being emptied this very cycle. The PE tails shift on the same edge
        // that captures colIn, so the pre-shift value is what lands in outData.
        fire = (beats_q < BEATS_ALL) & (~outValid_q | outReady);
        if (fire) begin
          enableShiftOut = 1'b1;
          outData_d      = narrowed;
          outValid_d     = 1'b1;
          outLast_d      = (beats_q == BEAT_LAST);
          beats_d        = beats_q + BEAT_ONE;
        end else if (accept) begin
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
          if (outLast_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mulCnt_q   <= '0;
      beats_q    <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mulCnt_q   <= mulCnt_d;
      beats_q    <= beats_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      outData_q  <= outData_d;
      done_q     <= done_d;
    end
  end

  assign outValid = outValid_q;
  assign outLast  = outLast_q;
  assign outData  = outData_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_enables_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(enableMul && enableShiftOut));

  a_idle_quiet : assert property (@(posedge clock) disable iff (reset)
    !busy |-> !(enableMul || enableShiftOut));

  a_stall_hold : assert property (@(posedge clock) disable iff (reset)
    (outValid && !outReady) |=> (outValid && $stable(outData) && $stable(outLast)));

endmodule

// File: tb/tb_paper_systolic_drain.sv
module tb_paper_systolic_drain;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ACC   = 32;
  localparam int OUT_W = 16;
  localparam int KW    = 16;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic [KW-1:0]         kLen;
  logic                  enableMul;
  logic                  enableShiftOut;
  logic [COLS*ACC-1:0]   colIn;
  logic                  outValid;
  logic                  outReady;
  logic [COLS*OUT_W-1:0] outData;
  logic                  outLast;
  logic                  busy;
  logic                  done;

  always #5 clock = ~clock;

  paper_systolic_drain #(
    .ROWS(ROWS), .COLS(COLS), .ACC(ACC), .OUT_W(OUT_W), .KW(KW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .kLen           (kLen),
    .enableMul      (enableMul),
    .enableShiftOut (enableShiftOut),
    .colIn          (colIn),
    .outValid       (outValid),
    .outReady       (outReady),
    .outData        (outData),
    .outLast        (outLast),
    .busy           (busy),
    .done           (done)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing, straight from the numeric definition.
  function automatic logic [OUT_W-1:0] ref_narrow(input logic [ACC-1:0] x);
    longint lim, s, r;
    lim = longint'(1) <<< (OUT_W - 1);
`ifdef PAPER_DRAIN_SATURATE_EN
    s = longint'($signed(x));
    if (s > lim - 1)   r = lim - 1;
    else if (s < -lim) r = -lim;
    else               r = s;
`else
    s = longint'(x);
    r = s % (lim * 2);
`endif
    return r[OUT_W-1:0];
  endfunction

  // PE array stand-in: tile matrix plus number of rows already shifted out.
  // After n shifts the tail of each column holds original row ROWS-1-n.
  logic [ACC-1:0] tile [ROWS][COLS];
  int nsh = 0;

  always @(posedge clock) begin
    if (start && !busy && !reset) nsh <= 0;
    else if (enableShiftOut)      nsh <= nsh + 1;
  end

  always_comb begin
    colIn = '0;
    for (int c = 0; c < COLS; c++) begin
      if (nsh < ROWS) colIn[c*ACC +: ACC] = tile[ROWS-1-nsh][c];
    end
  end

  typedef struct packed {
    logic [COLS*OUT_W-1:0] data;
    logic                  last;
  } beat_t;
  beat_t expq[$];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor state
  bit   active = 0;
  bit   allReady = 0;
  bit   curAllReady = 0;
  int   expMul, mulCnt, firstMul, lastMul;
  int   shCnt, firstSh, lastSh;
  int   accCnt = 0;
  int   lastAccCyc, startCyc;
  bit   stallPend = 0;
  logic [COLS*OUT_W-1:0] stallData, firstBeat;
  logic stallLast;

  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      active    = 0;
      stallPend = 0;
      expq.delete();
    end else begin
      chk_val("mul_shift_excl", {63'd0, enableMul & enableShiftOut}, 64'd0);
      if (!busy) chk_val("idle_enables", {62'd0, enableMul, enableShiftOut}, 64'd0);
      if (stallPend) begin
        chk_val("stall_valid", {63'd0, outValid}, 64'd1);
        chk_val("stall_data", 64'(outData), 64'(stallData));
        chk_val("stall_last", {63'd0, outLast}, {63'd0, stallLast});
        stallPend = 0;
      end
      if (enableMul) begin
        if (mulCnt == 0) firstMul = cyc;
        lastMul = cyc;
        mulCnt++;
      end
      if (enableShiftOut) begin
        if (shCnt == 0) firstSh = cyc;
        lastSh = cyc;
        shCnt++;
      end
      if (outValid && !outReady) begin
        chk_val("stall_no_shift", {63'd0, enableShiftOut}, 64'd0);
        stallPend = 1;
        stallData = outData;
        stallLast = outLast;
      end
      if (outValid && outReady) begin
        if (expq.size() == 0) begin
          chk_val("extra_beat", {63'd0, outValid}, 64'd0);
        end else begin
          e = expq.pop_front();
          chk_val("beat_data", 64'(outData), 64'(e.data));
          chk_val("beat_last", {63'd0, outLast}, {63'd0, e.last});
        end
        if (accCnt == 0) firstBeat = outData;
        accCnt++;
        lastAccCyc = cyc;
      end
      if (done) begin
        if (!active) begin
          chk_val("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          chk_val("done_latency", 64'(cyc), 64'(lastAccCyc + 1));
          chk_val("mul_cycles", 64'(mulCnt), 64'(expMul));
          if (expMul != 0) begin
            chk_val("mul_first", 64'(firstMul), 64'(startCyc + 1));
            chk_val("mul_contig", 64'(lastMul - firstMul + 1), 64'(mulCnt));
            chk_val("shift_after_mul", 64'(firstSh), 64'(lastMul + 1));
          end else begin
            chk_val("drain_first", 64'(firstSh), 64'(startCyc + 1));
          end
          chk_val("shift_count", 64'(shCnt), 64'(ROWS));
          chk_val("beat_count", 64'(accCnt), 64'(ROWS));
          if (curAllReady) chk_val("shift_contig", 64'(lastSh - firstSh + 1), 64'(ROWS));
          active = 0;
        end
      end
      if (start && !busy) begin
        active      = 1;
        startCyc    = cyc;
        expMul      = (kLen == 0) ? 0 : int'(kLen) + ROWS + COLS - 2;
        mulCnt      = 0;
        shCnt       = 0;
        accCnt      = 0;
        curAllReady = allReady;
      end
    end
  end

  function automatic logic [ACC-1:0] rand_acc();
    case ($urandom_range(0, 3))
      0: return ACC'($urandom);
      1: return ACC'($signed(17'($urandom)));
      2: begin
        logic [ACC-1:0] b [4];
        b[0] = 32'h0000_7FFF; b[1] = 32'hFFFF_8000;
        b[2] = 32'h0000_8000; b[3] = 32'hFFFF_7FFF;
        return b[$urandom_range(0, 3)];
      end
      default: return ACC'($urandom_range(0, 65535));
    endcase
  endfunction

  // mode: 0 = outReady held high, 1 = random outReady, 2 = 5-cycle stall after 2 beats
  // abortAfter >= 0: return once that many beats are accepted (no done expected)
  task automatic run_tile(input int k, input int mode, input bit poke,
                          input bit directed, input int abortAfter);
    int iter, budget, stallUsed;
    beat_t b;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tile[r][c] = rand_acc();
    if (directed) begin
      tile[ROWS-1][0] = 32'h0001_2345;
      tile[ROWS-1][1] = 32'hFFFF_0000;
      tile[ROWS-1][2] = 32'h0000_7FFF;
      tile[ROWS-1][3] = 32'hFFFF_8000;
    end
    for (int k2 = 0; k2 < ROWS; k2++) begin
      for (int c = 0; c < COLS; c++)
        b.data[c*OUT_W +: OUT_W] = ref_narrow(tile[ROWS-1-k2][c]);
      b.last = (k2 == ROWS - 1);
      expq.push_back(b);
    end
    allReady  = (mode == 0);
    stallUsed = 0;
    outReady  = (mode == 1) ? 1'($urandom) : 1'b1;
    kLen      = KW'(k);
    start     = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    iter   = 0;
    budget = k + ROWS + COLS + 200;
    while (!done && iter < budget) begin
      if (abortAfter >= 0 && accCnt >= abortAfter) break;
      case (mode)
        0: outReady = 1'b1;
        1: outReady = 1'($urandom);
        default: begin
          if (accCnt >= 2 && stallUsed < 5) begin
            outReady = 1'b0;
            stallUsed++;
          end else begin
            outReady = 1'b1;
          end
        end
      endcase
      start = poke && (iter == 2);
      if (start) kLen = KW'(7);
      @(posedge clock); #1;
      start = 1'b0;
      iter++;
    end
    if (abortAfter < 0) chk_val("tile_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] exp0, exp1;
    reset    = 1'b1;
    start    = 1'b0;
    kLen     = '0;
    outReady = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tile[r][c] = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_val("rst_busy", {63'd0, busy}, 64'd0);
    chk_val("rst_valid", {63'd0, outValid}, 64'd0);
    chk_val("rst_last", {63'd0, outLast}, 64'd0);
    chk_val("rst_data", 64'(outData), 64'd0);
    chk_val("rst_done", {63'd0, done}, 64'd0);
    chk_val("rst_enables", {62'd0, enableMul, enableShiftOut}, 64'd0);
    @(posedge clock); #1;

    // kLen=3: 9 multiply cycles, 4 back-to-back beats, narrowing boundaries.
    run_tile(3, 0, 0, 1, -1);
`ifdef PAPER_DRAIN_SATURATE_EN
    exp0 = 16'h7FFF; exp1 = 16'h8000;
`else
    exp0 = 16'h2345; exp1 = 16'h0000;
`endif
    chk_val("narrow_col0", 64'(firstBeat[OUT_W-1:0]), 64'(exp0));
    chk_val("narrow_col1", 64'(firstBeat[2*OUT_W-1:OUT_W]), 64'(exp1));

    // Backpressure mid-drain.
    run_tile(5, 2, 0, 0, -1);
    // Drain-only tile with a start poke while busy.
    run_tile(0, 0, 1, 0, -1);
    // Start poke during the multiply phase, random outReady.
    run_tile(4, 1, 1, 0, -1);

    for (int i = 0; i < 10; i++)
      run_tile(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'b0, -1);

    // Reset during the drain after two accepted beats.
    run_tile(2, 0, 0, 0, 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_val("abort_busy", {63'd0, busy}, 64'd0);
    chk_val("abort_valid", {63'd0, outValid}, 64'd0);
    chk_val("abort_last", {63'd0, outLast}, 64'd0);
    chk_val("abort_done", {63'd0, done}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk_val("abort_no_done", {63'd0, done}, 64'd0);
      chk_val("abort_no_valid", {63'd0, outValid}, 64'd0);
    end

    // Clean tile after the abort.
    run_tile(2, 1, 0, 0, -1);
    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
